// File: rtl/tdm_mux.sv
// -----------------------------------------------------------------------------
// tdm_mux
//
// N-channel, W-bit registered multiplexer with a valid/ready output handshake.
// Parametrised successor to the 2:1 combinational mux.
//
// Modes:
//   manual (MODE=0) : the channel is chosen by SEL.
//   scan   (MODE=1) : time-division round-robin over channels 0..N-1. Each
//                     channel is held for DWELL accepted samples (0 acts as 1).
//
// Ports:
//   CLK    in   1          rising-edge clock
//   RST_N  in   1          asynchronous, active-low reset
//   D      in   N*W        packed channel data, channel i at [i*W +: W]
//   SEL    in   SELW       manual-mode channel select
//   MODE   in   1          0 = manual, 1 = scan
//   DWELL  in   DWELL_W    loads per channel before scan advances (0 -> 1)
//   EN     in   1          sample enable
//   Y      out  W          registered selected data
//   CH     out  SELW       channel index that produced Y
//   VLD    out  1          Y/CH hold a sample not yet accepted
//   RDY    in   1          consumer ready
//
// Every output comes straight from a flop. D, SEL and RDY only reach the
// outputs through the registers.
// -----------------------------------------------------------------------------
module tdm_mux #(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int SELW    = 2,
    parameter int DWELL_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N*W-1:0]       D,
    input  logic [SELW-1:0]      SEL,
    input  logic                 MODE,
    input  logic [DWELL_W-1:0]   DWELL,
    input  logic                 EN,
    output logic [W-1:0]         Y,
    output logic [SELW-1:0]      CH,
    output logic                 VLD,
    input  logic                 RDY
);

    // Output registers
    logic [W-1:0]       y_q,    y_d;
    logic [SELW-1:0]    ch_q,   ch_d;
    logic               vld_q,  vld_d;

    // Scan state: current channel pointer and loads taken on that channel
    logic [SELW-1:0]    ptr_q,  ptr_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;

    // Combinational helpers
    logic               load_s;
    logic               accept_s;
    logic [SELW-1:0]    chan_s;
    logic [W-1:0]       sel_data_s;
    logic [DWELL_W-1:0] dw_m1_s;
    logic               ptr_last_s;
    logic               dwell_done_s;

    // Load/accept decode and channel choice for this edge
    always_comb begin
        load_s   = EN & (~vld_q | RDY);
        accept_s = vld_q & RDY;
        chan_s   = MODE ? ptr_q : SEL;
    end

    // Channel data select. A channel index with no matching input (only
    // reachable through SEL when N is not a power of two) yields zero.
    always_comb begin
        sel_data_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_data_s = (chan_s == SELW'(i)) ? D[i*W +: W] : sel_data_s;
        end
    end

    // Dwell threshold. DWELL=0 behaves as 1, so the threshold is DW-1 with
    // DW = max(DWELL,1). Using >= lets a lowered DWELL take effect at the
    // next load instead of waiting for the counter to wrap.
    always_comb begin
        if (DWELL == {DWELL_W{1'b0}}) begin
            dw_m1_s = {DWELL_W{1'b0}};
        end else begin
            dw_m1_s = DWELL - DWELL_W'(1'b1);
        end
        dwell_done_s = (dcnt_q >= dw_m1_s);
        // Explicit wrap at N-1: N need not be a power of two.
        ptr_last_s   = (ptr_q == SELW'(N - 1));
    end

    // Output register next-state: load, accept/drop, or hold (stall/idle)
    always_comb begin
        y_d   = y_q;
        ch_d  = ch_q;
        vld_d = vld_q;
        if (load_s) begin
            y_d   = sel_data_s;
            ch_d  = chan_s;
            vld_d = 1'b1;
        end else if (accept_s) begin
            // Consumer took the sample and nothing new is enabled:
            // drop VLD but keep Y/CH as the last value.
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end
    end

    // Scan counter next-state. Manual mode parks the scan at channel 0 with
    // a fresh dwell on every edge, so re-entering scan always starts clean.
    always_comb begin
        ptr_d  = ptr_q;
        dcnt_d = dcnt_q;
        if (!MODE) begin
            ptr_d  = {SELW{1'b0}};
            dcnt_d = {DWELL_W{1'b0}};
        end else if (load_s) begin
            if (dwell_done_s) begin
                dcnt_d = {DWELL_W{1'b0}};
                if (ptr_last_s) begin
                    ptr_d = {SELW{1'b0}};
                end else begin
                    ptr_d = ptr_q + SELW'(1'b1);
                end
            end else begin
                dcnt_d = dcnt_q + DWELL_W'(1'b1);
            end
        end else begin
            ptr_d  = ptr_q;
            dcnt_d = dcnt_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            y_q    <= {W{1'b0}};
            ch_q   <= {SELW{1'b0}};
            vld_q  <= 1'b0;
            ptr_q  <= {SELW{1'b0}};
            dcnt_q <= {DWELL_W{1'b0}};
        end else begin
            y_q    <= y_d;
            ch_q   <= ch_d;
            vld_q  <= vld_d;
            ptr_q  <= ptr_d;
            dcnt_q <= dcnt_d;
        end
    end

    assign Y   = y_q;
    assign CH  = ch_q;
    assign VLD = vld_q;

endmodule

// File: tb/tb_tdm_mux.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux
//
// Self-checking bench for tdm_mux. Two instances share the control inputs:
// a 4-channel one and a 3-channel one (out-of-range SEL and non-power-of-two
// scan wrap). A behavioural model tracks both; directed tables and sequences
// add fixed expectations for the key corner cases.
// -----------------------------------------------------------------------------
module tb_tdm_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] d4;
    logic [23:0] d3;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  dwell;
    logic        en;
    logic        rdy;
    logic [7:0]  y4, y3;
    logic [1:0]  ch4, ch3;
    logic        vld4, vld3;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state, index 0 = 4-channel DUT, 1 = 3-channel DUT
    int m_y[2];
    int m_ch[2];
    int m_vld[2];
    int m_ptr[2];
    int m_cnt[2];
    int nch[2] = '{4, 3};

    tdm_mux #(.W(8), .N(4), .SELW(2), .DWELL_W(8)) dut4 (
        .CLK(clk), .RST_N(rst_n), .D(d4), .SEL(sel), .MODE(mode),
        .DWELL(dwell), .EN(en), .Y(y4), .CH(ch4), .VLD(vld4), .RDY(rdy)
    );

    tdm_mux #(.W(8), .N(3), .SELW(2), .DWELL_W(8)) dut3 (
        .CLK(clk), .RST_N(rst_n), .D(d3), .SEL(sel), .MODE(mode),
        .DWELL(dwell), .EN(en), .Y(y3), .CH(ch3), .VLD(vld3), .RDY(rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int chan_data(input int k, input int c);
        if (c >= nch[k]) return 0;
        if (k == 0) return int'(d4[c*8 +: 8]);
        return int'(d3[c*8 +: 8]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_y[k] = 0; m_ch[k] = 0; m_vld[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // One rising edge of the model, from the current input values
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit load;
            int c;
            int dw;
            load = en && (!m_vld[k] || rdy);
            c    = mode ? m_ptr[k] : int'(sel);
            dw   = (dwell == 8'd0) ? 1 : int'(dwell);
            if (load) begin
                m_y[k]   = chan_data(k, c);
                m_ch[k]  = c;
                m_vld[k] = 1;
            end else if (m_vld[k] && rdy) begin
                m_vld[k] = 0;
            end
            if (!mode) begin
                m_ptr[k] = 0;
                m_cnt[k] = 0;
            end else if (load) begin
                m_cnt[k]++;
                if (m_cnt[k] >= dw) begin
                    m_cnt[k] = 0;
                    m_ptr[k] = (m_ptr[k] + 1) % nch[k];
                end
            end
        end
    endtask

    task automatic compare_model();
        chk("model_y4",   int'(y4),   m_y[0]);
        chk("model_ch4",  int'(ch4),  m_ch[0]);
        chk("model_vld4", int'(vld4), m_vld[0]);
        chk("model_y3",   int'(y3),   m_y[1]);
        chk("model_ch3",  int'(ch3),  m_ch[1]);
        chk("model_vld3", int'(vld3), m_vld[1]);
    endtask

    // Apply current inputs across one edge and check outputs 1 time unit later
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    // Park scan state at channel 0 without loading (MODE=0, EN=0 edge)
    task automatic park();
        mode = 1'b0; en = 1'b0; rdy = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic       rdy;
        int         exp_y4;
        int         exp_y3;
        int         exp_ch;
        int         exp_vld;
    } vec_t;

    vec_t vecs[8];

    int exp_dw2_4[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp_dw2_3[10] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
    int exp_dw0_4[6]  = '{0, 1, 2, 3, 0, 1};
    int exp_dw0_3[6]  = '{0, 1, 2, 0, 1, 2};

    initial begin
        int y1_4;
        int y1_3;

        rst_n = 1'b0;
        d4 = 32'h44332211; d3 = 24'h332211;
        sel = 2'd0; mode = 1'b0; dwell = 8'd1; en = 1'b0; rdy = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_y4", int'(y4), 0);
        chk("rst_ch4", int'(ch4), 0);
        chk("rst_vld4", int'(vld4), 0);

        // ---- Manual + latency + out-of-range table ----
        vecs[0] = '{2'd0, 1'b1, 1'b1, 'h11, 'h11, 0, 1};
        vecs[1] = '{2'd1, 1'b1, 1'b1, 'h22, 'h22, 1, 1};
        vecs[2] = '{2'd2, 1'b1, 1'b1, 'h33, 'h33, 2, 1};
        vecs[3] = '{2'd3, 1'b1, 1'b1, 'h44, 'h00, 3, 1};
        vecs[4] = '{2'd0, 1'b0, 1'b1, 'h44, 'h00, 3, 0};  // drop
        vecs[5] = '{2'd1, 1'b1, 1'b0, 'h22, 'h22, 1, 1};  // load into empty
        vecs[6] = '{2'd2, 1'b1, 1'b0, 'h22, 'h22, 1, 1};  // stall, SEL ignored
        vecs[7] = '{2'd3, 1'b1, 1'b1, 'h44, 'h00, 3, 1};
        mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].sel; en = vecs[i].en; rdy = vecs[i].rdy;
            tick();
            chk($sformatf("tbl%0d_y4", i),  int'(y4),  vecs[i].exp_y4);
            chk($sformatf("tbl%0d_y3", i),  int'(y3),  vecs[i].exp_y3);
            chk($sformatf("tbl%0d_ch4", i), int'(ch4), vecs[i].exp_ch);
            chk($sformatf("tbl%0d_ch3", i), int'(ch3), vecs[i].exp_ch);
            chk($sformatf("tbl%0d_vld", i), int'(vld4), vecs[i].exp_vld);
        end

        // ---- Asynchronous reset mid-handshake ----
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_y4", int'(y4), 0);
        chk("arst_ch4", int'(ch4), 0);
        chk("arst_vld4", int'(vld4), 0);
        chk("arst_vld3", int'(vld3), 0);
        #3;
        rst_n = 1'b1;
        en = 1'b0; rdy = 1'b1;
        tick();
        chk("idle_vld4", int'(vld4), 0);

        // ---- Scan with dwell 2, then dwell 0 ----
        park();
        mode = 1'b1; dwell = 8'd2; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("scan2_ch4_%0d", i), int'(ch4), exp_dw2_4[i]);
            chk($sformatf("scan2_ch3_%0d", i), int'(ch3), exp_dw2_3[i]);
        end
        park();
        mode = 1'b1; dwell = 8'd0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("scan0_ch4_%0d", i), int'(ch4), exp_dw0_4[i]);
            chk($sformatf("scan0_ch3_%0d", i), int'(ch3), exp_dw0_3[i]);
        end

        // ---- Backpressure in scan, dwell 1 ----
        park();
        mode = 1'b1; dwell = 8'd1; en = 1'b1; rdy = 1'b1;
        tick();
        chk("bp_first_ch4", int'(ch4), 0);
        y1_4 = int'(d4[15:8]);
        y1_3 = int'(d3[15:8]);
        tick();
        chk("bp_load_ch4", int'(ch4), 1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4 = $urandom; d3 = 24'($urandom);
            tick();
            chk("bp_hold_y4", int'(y4), y1_4);
            chk("bp_hold_y3", int'(y3), y1_3);
            chk("bp_hold_ch4", int'(ch4), 1);
            chk("bp_hold_vld4", int'(vld4), 1);
        end
        rdy = 1'b1;
        tick();
        chk("bp_next_ch4", int'(ch4), 2);
        chk("bp_next_y4", int'(y4), int'(d4[23:16]));
        chk("bp_next_ch3", int'(ch3), 2);

        // ---- Mode switch at PTR=2, DCNT=1 (dwell 2) plus drop ----
        park();
        mode = 1'b1; dwell = 8'd2; en = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("ms_pre_ch4", int'(ch4), 2);
        mode = 1'b0; en = 1'b0; rdy = 1'b1;
        tick();
        chk("drop_vld4", int'(vld4), 0);
        chk("drop_ch4", int'(ch4), 2);
        mode = 1'b1; en = 1'b1;
        tick();
        chk("ms_ch4_a", int'(ch4), 0);
        tick();
        chk("ms_ch4_b", int'(ch4), 0);
        tick();
        chk("ms_ch4_c", int'(ch4), 1);

        // ---- Randomised run against the model ----
        for (int i = 0; i < 400; i++) begin
            d4    = $urandom;
            d3    = 24'($urandom);
            sel   = 2'($urandom_range(0, 3));
            dwell = 8'($urandom_range(0, 3));
            en    = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
